rv_cmp_serial: RTL and testbench

RV_CMP_SERIAL -- requirements
Module: rv_cmp_serial

---
 rtl/rv_cmp_pkg.sv | 30 +++
 rtl/rv_cmp_chunk.sv | 14 +
 rtl/rv_cmp_serial.sv | 176 +++++++++++++++++
 tb/tb_rv_cmp_serial.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_cmp_pkg.sv
// rtl/rv_cmp_pkg.sv - compare opcode enum, FSM state type and opcode classification helpers
package rv_cmp_pkg;

   typedef enum logic [3:0] {
      EQ    = 4'd0,
      NE    = 4'd1,
      GE    = 4'd2,
      GEU   = 4'd3,
      SLT   = 4'd5,
      SLTU  = 4'd6,
      MIN   = 4'd7,
      MAX   = 4'd8,
      MINU  = 4'd9,
      MAXU  = 4'd10,
      SLTI  = 4'd12,
      SLTIU = 4'd13
   } cmp_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } cmp_state_e;

   // Signed ops flip the sign bit so an unsigned chunk compare orders them correctly.
   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == SLT) || (op == SLTI) || (op == GE) || (op == MIN) || (op == MAX);
   endfunction

endpackage

// File: rtl/rv_cmp_chunk.sv
// rtl/rv_cmp_chunk.sv - combinational CHUNK-bit unsigned less-than / equal slice
module rv_cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic             lt_o,
   output logic             eq_o
);

   assign lt_o = (a_i < b_i);
   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/rv_cmp_serial.sv
// rtl/rv_cmp_serial.sv - serial MSB-first chunked comparator; CMP_EARLY_EXIT_EN ends BUSY at first unequal chunk
module rv_cmp_serial
   import rv_cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [3:0]       alu_opsel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_cfg
         $error("rv_cmp_serial: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   cmp_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       op_q, op_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             lt_q, lt_d, gt_q, gt_d;
   logic             flag_q, flag_d;

   logic [WIDTH-1:0] bias, a_cmp, b_cmp;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             c_lt, c_eq;
   logic             decided, fin_lt, fin_eq, last_chunk;
   logic             calc_flag;
   logic [WIDTH-1:0] calc_result;

   assign bias    = is_signed_op(op_q) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
   assign a_cmp   = a_q ^ bias;
   assign b_cmp   = b_q ^ bias;
   assign a_chunk = a_cmp[int'(idx_q)*CHUNK +: CHUNK];
   assign b_chunk = b_cmp[int'(idx_q)*CHUNK +: CHUNK];

   rv_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i  (a_chunk),
      .b_i  (b_chunk),
      .lt_o (c_lt),
      .eq_o (c_eq)
   );

   // Once a higher chunk has differed, its lt/gt decision is final.
   always_comb begin
      decided    = lt_q | gt_q;
      fin_lt     = decided ? lt_q : c_lt;
      fin_eq     = !decided && c_eq;
      last_chunk = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
      if (!decided && !c_eq) begin
         last_chunk = 1'b1;
      end
`endif
   end

   always_comb begin
      calc_flag   = 1'b0;
      calc_result = '0;
      case (op_q)
         EQ:                     calc_flag = fin_eq;
         NE:                     calc_flag = !fin_eq;
         GE, GEU:                calc_flag = !fin_lt;
         SLT, SLTI, SLTU, SLTIU: calc_flag = fin_lt;
         MIN, MINU: begin
            calc_flag   = fin_lt;
            calc_result = fin_lt ? a_q : b_q;
         end
         MAX, MAXU: begin
            calc_flag   = fin_lt;
            calc_result = fin_lt ? b_q : a_q;
         end
         default: begin
            calc_flag   = 1'b0;
            calc_result = '0;
         end
      endcase
      if ((op_q == EQ) || (op_q == NE) || (op_q == GE) || (op_q == GEU) ||
          (op_q == SLT) || (op_q == SLTI) || (op_q == SLTU) || (op_q == SLTIU)) begin
         calc_result = {{(WIDTH-1){1'b0}}, calc_flag};
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      idx_d    = idx_q;
      lt_d     = lt_q;
      gt_d     = gt_q;
      result_d = result_q;
      flag_d   = flag_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = opA;
               b_d     = opB;
               op_d    = alu_opsel;
               idx_d   = IDXW'(N - 1);
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!decided) begin
               lt_d = c_lt;
               gt_d = !c_lt && !c_eq;
            end
            idx_d = idx_q - IDXW'(1);
            if (last_chunk) begin
               result_d = calc_result;
               flag_d   = calc_flag;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         idx_q    <= '0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         result_q <= '0;
         flag_q   <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         lt_q     <= lt_d;
         gt_q     <= gt_d;
         result_q <= result_d;
         flag_q   <= flag_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign flag      = flag_q;

endmodule

// File: tb/tb_rv_cmp_serial.sv
// tb/tb_rv_cmp_serial.sv - vector table, handshake corner sequences and randomized model check for rv_cmp_serial
module tb_rv_cmp_serial;
   import rv_cmp_pkg::*;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] opA, opB;
   logic [3:0]  alu_opsel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv_cmp_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opA       (opA),
      .opB       (opB),
      .alu_opsel (alu_opsel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag      (flag)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic on the whole operands.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic f);
      logic slt, ult, eq;
      slt = $signed(a) < $signed(b);
      ult = a < b;
      eq  = (a == b);
      res = '0;
      f   = 1'b0;
      case (op)
         EQ:          begin f = eq;   res = 32'(f); end
         NE:          begin f = !eq;  res = 32'(f); end
         GE:          begin f = !slt; res = 32'(f); end
         GEU:         begin f = !ult; res = 32'(f); end
         SLT, SLTI:   begin f = slt;  res = 32'(f); end
         SLTU, SLTIU: begin f = ult;  res = 32'(f); end
         MIN:         begin f = slt;  res = slt ? a : b; end
         MAX:         begin f = slt;  res = slt ? b : a; end
         MINU:        begin f = ult;  res = ult ? a : b; end
         MAXU:        begin f = ult;  res = ult ? b : a; end
         default:     begin f = 1'b0; res = '0; end
      endcase
   endtask

   // Cycles from accept to out_valid: 1 + chunks examined (first differing chunk from the top, or all).
   function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      int k;
      d = a ^ b;
      k = N;
      for (int j = 0; j < WIDTH; j++) if (d[j]) k = N - j / CHUNK;
`ifndef CMP_EARLY_EXIT_EN
      k = N;
`endif
      return 1 + k;
   endfunction

   task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic f, output int lat, output logic ok);
      int n;
      @(negedge clk);
      opA = a; opB = b; alu_opsel = op; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; lat++; n++; end
      ok  = out_valid;
      res = result;
      f   = flag;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        f;
      int          lat_ee;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] r, er, r0;
      logic        f, ef, ok, f0;
      int          lat, elat, n;
      logic [31:0] a, b;
      logic [3:0]  op;

      vecs[0]  = '{SLT,   32'hFFFFFFFF, 32'h00000001, 32'h1,        1'b1, 2};
      vecs[1]  = '{SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 2};
      vecs[2]  = '{EQ,    32'h12345678, 32'h12345678, 32'h1,        1'b1, 5};
      vecs[3]  = '{MIN,   32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 2};
      vecs[4]  = '{MAXU,  32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 2};
      vecs[5]  = '{4'hF,  32'h00000001, 32'h00000002, 32'h0,        1'b0, 5};
      vecs[6]  = '{NE,    32'h000000AA, 32'h000000AB, 32'h1,        1'b1, 5};
      vecs[7]  = '{GE,    32'h00001000, 32'hFFFF0000, 32'h1,        1'b1, 2};
      vecs[8]  = '{GEU,   32'h00001000, 32'hFFFF0000, 32'h0,        1'b0, 2};
      vecs[9]  = '{SLTI,  32'h00120000, 32'h00130000, 32'h1,        1'b1, 3};
      vecs[10] = '{MAX,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5};
      vecs[11] = '{MINU,  32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 3};
      vecs[12] = '{SLTIU, 32'h00000005, 32'h00000005, 32'h0,        1'b0, 5};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      opA = '0; opB = '0; alu_opsel = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.out_valid", 32'(out_valid), 32'h0);
      check("reset.in_ready",  32'(in_ready),  32'h1);
      check("reset.result",    result,         32'h0);
      check("reset.flag",      32'(flag),      32'h0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_txn(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, ok);
`ifdef CMP_EARLY_EXIT_EN
         elat = vecs[i].lat_ee;
`else
         elat = 1 + N;
`endif
         check($sformatf("vec%0d.done", i),   32'(ok),  32'h1);
         check($sformatf("vec%0d.result", i), r,        vecs[i].res);
         check($sformatf("vec%0d.flag", i),   32'(f),   32'(vecs[i].f));
         check($sformatf("vec%0d.latency", i), 32'(lat), 32'(elat));
      end

      // Held response under backpressure while in_valid pulses; accept only after consume.
      @(negedge clk);
      out_ready = 1'b0; opA = 32'hFFFFFFFF; opB = 32'h1; alu_opsel = SLT; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("hold.reached", 32'(out_valid), 32'h1);
      r0 = result; f0 = flag;
      check("hold.first_result", r0, 32'h1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = (c != 1); opA = $urandom; opB = $urandom; alu_opsel = EQ;
         @(posedge clk); #1;
         check($sformatf("hold%0d.out_valid", c), 32'(out_valid), 32'h1);
         check($sformatf("hold%0d.in_ready", c),  32'(in_ready),  32'h0);
         check($sformatf("hold%0d.result", c),    result,         r0);
         check($sformatf("hold%0d.flag", c),      32'(flag),      32'(f0));
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; opA = 32'h10; opB = 32'h20; alu_opsel = MINU;
      @(posedge clk); #1;
      check("consume.out_valid", 32'(out_valid), 32'h0);
      check("consume.in_ready",  32'(in_ready),  32'h1);
      @(posedge clk); #1;
      check("next.accepted", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("next.reached", 32'(out_valid), 32'h1);
      check("next.result",  result,         32'h10);
      @(posedge clk); #1;

      // Reset mid-BUSY, then reset colliding with a request.
      @(negedge clk);
      opA = 32'h1; opB = 32'h2; alu_opsel = SLT; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("rst.out_valid", 32'(out_valid), 32'h0);
      check("rst.in_ready",  32'(in_ready),  32'h1);
      check("rst.result",    result,         32'h0);
      check("rst.flag",      32'(flag),      32'h0);
      @(negedge clk); in_valid = 1'b1;
      @(posedge clk); #1;
      check("rst_vs_valid.in_ready", 32'(in_ready), 32'h1);
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("rst.discarded", 32'(out_valid), 32'h0);

      // Randomized traffic against the arithmetic model.
      for (int t = 0; t < 200; t++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = a;
            2: b = a ^ (32'h1 << $urandom_range(0, 31));
            default: begin
               for (int j = 0; j < N; j++) begin
                  a[j*CHUNK +: CHUNK] = 8'($urandom_range(0, 1) ? 8'h80 : 8'h7F);
                  b[j*CHUNK +: CHUNK] = 8'($urandom_range(0, 1) ? 8'hFF : 8'h7F);
               end
            end
         endcase
         model(op, a, b, er, ef);
         run_txn(op, a, b, r, f, lat, ok);
         check($sformatf("rand%0d.done op=%0d", t, op), 32'(ok), 32'h1);
         check($sformatf("rand%0d.result op=%0d a=%08h b=%08h", t, op, a, b), r, er);
         check($sformatf("rand%0d.flag op=%0d a=%08h b=%08h", t, op, a, b), 32'(f), 32'(ef));
         check($sformatf("rand%0d.latency a=%08h b=%08h", t, a, b), 32'(lat), 32'(exp_latency(a, b)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
